// File: rtl/bit_index_serializer.sv
// Bit index serializer.
// Accepts a WIDTH-bit vector over a valid/ready handshake. It then emits the
// position of each set bit as one beat, lowest bit first. The final beat of
// each vector is flagged. An all-zero vector still produces exactly one beat,
// flagged both empty and last, so the consumer always sees a terminating beat.
// Every output is decoded from registered state only.
module bit_index_serializer #(
  parameter int WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     arst_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     data_val_i,
  output logic                     data_ready_o,
  output logic [$clog2(WIDTH)-1:0] index_o,
  output logic                     index_empty_o,
  output logic                     index_last_o,
  output logic                     index_val_o,
  input  logic                     index_ready_i
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             dataReady_q, dataReady_d;

  logic [IW-1:0]    lowIdx;
  logic [WIDTH-1:0] pendCleared;
  logic             pendEmpty;
  logic             pendSingle;

  // Priority-encode the lowest set bit of the pending vector. The loop scans
  // from the top down, so the last hit (the lowest bit) wins.
  always_comb begin
    lowIdx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        lowIdx = IW'(i);
      end
    end
  end

  // x & (x-1) removes the lowest set bit. If that leaves nothing and the
  // vector was non-zero, the current bit is the final one.
  always_comb begin
    pendCleared = pend_q & (pend_q - WIDTH'(1));
    pendEmpty   = (pend_q == '0);
    pendSingle  = !pendEmpty && (pendCleared == '0);
  end

  // Next-state and output decode for the IDLE/SEND controller.
  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    dataReady_d   = dataReady_q;
    index_o       = '0;
    index_empty_o = 1'b0;
    index_last_o  = 1'b0;
    index_val_o   = 1'b0;

    unique case (state_q)
      IDLE: begin
        dataReady_d = 1'b1;
        if (data_val_i && dataReady_q) begin
          pend_d      = data_i;
          state_d     = SEND;
          dataReady_d = 1'b0;
        end
      end

      SEND: begin
        index_val_o = 1'b1;
        if (pendEmpty) begin
          index_empty_o = 1'b1;
          index_last_o  = 1'b1;
        end else begin
          index_o      = lowIdx;
          index_last_o = pendSingle;
        end
        if (index_ready_i) begin
          pend_d = pendCleared;
          if (pendEmpty || pendSingle) begin
            state_d     = IDLE;
            dataReady_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers. Reset discards any partially sent vector. data_ready
  // stays low until the first edge after reset is released.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      dataReady_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      dataReady_q <= dataReady_d;
    end
  end

  assign data_ready_o = dataReady_q;

endmodule

// File: tb/tb_bit_index_serializer.sv
// Directed and randomized checks for bit_index_serializer.
// The WIDTH=16 instance carries most of the tests. A WIDTH=10 instance covers
// a vector width that is not a power of two.
module tb_bit_index_serializer;

  logic        clk_i = 1'b0;
  logic        arst_i = 1'b1;
  logic [15:0] data_i = '0;
  logic        data_val_i = 1'b0;
  logic        data_ready_o;
  logic [3:0]  index_o;
  logic        index_empty_o;
  logic        index_last_o;
  logic        index_val_o;
  logic        index_ready_i = 1'b0;

  logic [9:0]  d10Data = '0;
  logic        d10Val = 1'b0;
  logic        d10DataReady;
  logic [3:0]  d10Idx;
  logic        d10Empty;
  logic        d10Last;
  logic        d10IdxVal;
  logic        d10Ready = 1'b1;

  int assertCount = 0;
  int failCount   = 0;

  bit_index_serializer #(.WIDTH(16)) u_dut (
    .clk_i         (clk_i),
    .arst_i        (arst_i),
    .data_i        (data_i),
    .data_val_i    (data_val_i),
    .data_ready_o  (data_ready_o),
    .index_o       (index_o),
    .index_empty_o (index_empty_o),
    .index_last_o  (index_last_o),
    .index_val_o   (index_val_o),
    .index_ready_i (index_ready_i)
  );

  bit_index_serializer #(.WIDTH(10)) u_dut10 (
    .clk_i         (clk_i),
    .arst_i        (arst_i),
    .data_i        (d10Data),
    .data_val_i    (d10Val),
    .data_ready_o  (d10DataReady),
    .index_o       (d10Idx),
    .index_empty_o (d10Empty),
    .index_last_o  (d10Last),
    .index_val_o   (d10IdxVal),
    .index_ready_i (d10Ready)
  );

  // Free-running 10 ns clock.
  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] vec, input logic val, input logic rdy);
    data_i        = vec;
    data_val_i    = val;
    index_ready_i = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic expVal, input int expIdx,
                             input logic expLast, input logic expEmpty, input logic expDataReady);
    checkEq({tag, ".val"},   32'(index_val_o),   32'(expVal));
    checkEq({tag, ".idx"},   32'(index_o),       32'(expIdx));
    checkEq({tag, ".last"},  32'(index_last_o),  32'(expLast));
    checkEq({tag, ".empty"}, 32'(index_empty_o), 32'(expEmpty));
    checkEq({tag, ".dRdy"},  32'(data_ready_o),  32'(expDataReady));
  endtask

  task automatic check10(input string tag, input logic expVal, input int expIdx,
                         input logic expLast, input logic expDataReady);
    checkEq({tag, ".val"},  32'(d10IdxVal),    32'(expVal));
    checkEq({tag, ".idx"},  32'(d10Idx),       32'(expIdx));
    checkEq({tag, ".last"}, 32'(d10Last),      32'(expLast));
    checkEq({tag, ".empty"}, 32'(d10Empty),    32'b0);
    checkEq({tag, ".dRdy"}, 32'(d10DataReady), 32'(expDataReady));
  endtask

  task automatic reportTimeout(input string tag);
    assertCount++;
    failCount++;
    $error("[TB] FAIL %s timeout observed=expired expected=completed", tag);
  endtask

  // Send one vector and follow its beats against a list of set-bit positions
  // built here. Junk data is driven on data_i while the vector is being sent.
  task automatic runVector(input logic [15:0] vec, input bit useStall);
    int  pos[$];
    int  k;
    int  nBeats;
    int  cycles;
    bit  rdy;
    for (int i = 0; i < 16; i++) begin
      if (vec[i]) pos.push_back(i);
    end
    nBeats = (pos.size() == 0) ? 1 : pos.size();
    cycles = 0;
    while (!data_ready_o && cycles < 50) begin
      tick();
      cycles++;
    end
    if (!data_ready_o) begin
      reportTimeout("rndAccept");
      return;
    end
    applyStimulus(vec, 1'b1, 1'b1);
    tick();
    k = 0;
    cycles = 0;
    while (k < nBeats && cycles < 200) begin
      rdy = useStall ? ($urandom_range(0, 2) != 0) : 1'b1;
      applyStimulus(16'($urandom), 1'b1, rdy);
      if (pos.size() == 0) begin
        checkOutput("rndEmpty", 1'b1, 0, 1'b1, 1'b1, 1'b0);
      end else begin
        checkOutput("rndBeat", 1'b1, pos[k], (k == pos.size() - 1), 1'b0, 1'b0);
      end
      data_val_i = (k == nBeats - 1 && rdy) ? 1'b0 : 1'b1;
      tick();
      if (rdy) k++;
      cycles++;
    end
    if (k < nBeats) begin
      reportTimeout("rndBeats");
    end
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkOutput("rndIdle", 1'b0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    // Reset state and release
    applyStimulus(16'h0000, 1'b0, 1'b0);
    #3;
    checkOutput("reset", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("resetHeld", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    arst_i = 1'b0;
    #1;
    checkOutput("resetReleased", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("readyAfterReset", 1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Basic enumeration of 16'h8421
    applyStimulus(16'h8421, 1'b1, 1'b1);
    tick();
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkOutput("basic0", 1'b1, 0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("basic5", 1'b1, 5, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("basic10", 1'b1, 10, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("basic15", 1'b1, 15, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("basicIdle", 1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Empty vector
    applyStimulus(16'h0000, 1'b1, 1'b1);
    tick();
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkOutput("empty", 1'b1, 0, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("emptyIdle", 1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Backpressure with ready pattern 0,0,1,0,1 on 16'h0030
    applyStimulus(16'h0030, 1'b1, 1'b0);
    tick();
    applyStimulus(16'h0000, 1'b0, 1'b0);
    checkOutput("bpStall1", 1'b1, 4, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("bpStall2", 1'b1, 4, 1'b0, 1'b0, 1'b0);
    index_ready_i = 1'b1;
    tick();
    index_ready_i = 1'b0;
    checkOutput("bpNext", 1'b1, 5, 1'b1, 1'b0, 1'b0);
    tick();
    index_ready_i = 1'b1;
    checkOutput("bpHold", 1'b1, 5, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("bpIdle", 1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Back-to-back vectors with data_val_i held high
    applyStimulus(16'h0001, 1'b1, 1'b1);
    tick();
    applyStimulus(16'h0003, 1'b1, 1'b1);
    checkOutput("b2bFirst", 1'b1, 0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("b2bBubble", 1'b0, 0, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(16'hFFFF, 1'b1, 1'b1);
    checkOutput("b2bSecond0", 1'b1, 0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkOutput("b2bSecond1", 1'b1, 1, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("b2bIdle", 1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a vector
    applyStimulus(16'h00FF, 1'b1, 1'b1);
    tick();
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkOutput("rstBeat0", 1'b1, 0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("rstBeat1", 1'b1, 1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("rstBeat2", 1'b1, 2, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("rstBeat3", 1'b1, 3, 1'b0, 1'b0, 1'b0);
    #2;
    arst_i = 1'b1;
    #1;
    checkOutput("rstAsync", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    tick();
    #2;
    arst_i = 1'b0;
    #1;
    checkOutput("rstReleased", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("rstReady", 1'b0, 0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("rstNoStale", 1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Full vector
    runVector(16'hFFFF, 1'b0);

    // Non-power-of-two width
    check10("w10Idle", 1'b0, 0, 1'b0, 1'b1);
    d10Data = 10'b10_0000_0001;
    d10Val  = 1'b1;
    tick();
    d10Val  = 1'b0;
    d10Data = '0;
    check10("w10Beat0", 1'b1, 0, 1'b0, 1'b0);
    tick();
    check10("w10Beat9", 1'b1, 9, 1'b1, 1'b0);
    tick();
    check10("w10Done", 1'b0, 0, 1'b0, 1'b1);

    // Randomized vectors with random backpressure
    for (int n = 0; n < 30; n++) begin
      runVector(16'($urandom), 1'b1);
    end
    runVector(16'h8000, 1'b1);
    runVector(16'h0000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/bit_index_serializer.md
# bit_index_serializer

Streams out the bit positions of every set bit in an accepted WIDTH-bit vector, one index per transfer, LSB first, with a last-beat marker. It is the expanding counterpart of the bit population counter: where that block reduces a vector to a count, this block enumerates the individual set bits for downstream per-bit processing. The input side uses a valid/ready handshake and the output side uses a valid/ready stream with backpressure.

## Interface
- WIDTH, 16: input vector width; legal range WIDTH >= 2; need not be a power of two.
- IW (localparam) = $clog2(WIDTH): index width.
- clk_i  input  1  clock; all logic on rising edge.
- arst_i  input  1  asynchronous, active-high reset.
- data_i  input  WIDTH  vector to enumerate.
- data_val_i  input  1  data_i valid.
- data_ready_o  output  1  block can accept a vector; transfer when data_val_i & data_ready_o.
- index_o  output  IW  position of the current set bit; 0 on an empty beat.
- index_empty_o  output  1  current beat reports an all-zero vector.
- index_last_o  output  1  current beat is the final beat of the vector.
- index_val_o  output  1  index_o, index_empty_o, and index_last_o are valid.
- index_ready_i  input  1  consumer accepts the beat; beat transfers when index_val_o & index_ready_i.

## Operation
- Two states: IDLE and SEND. State, shadow vector `pend`, and data_ready_o are registers.
- **IDLE**
  - data_ready_o = 1; index_val_o = 0.
  - On input transfer: pend <= data_i, state <= SEND, data_ready_o <= 0.
- **SEND**
  - index_val_o = 1; data_ready_o = 0.
  - If pend == 0 (empty vector): index_empty_o = 1, index_last_o = 1, index_o = 0.
  - Otherwise:
    - index_o = position of the lowest set bit of pend;
    - index_empty_o = 0;
    - index_last_o = 1 only when pend has exactly one bit set.
  - On output transfer:
    - clear the lowest set bit of pend;
    - if the beat was last: state <= IDLE, data_ready_o <= 1.
  - Without index_ready_i: index_o, index_empty_o, and index_last_o stay unchanged and index_val_o stays high. No beat may be dropped or changed while stalled.
- Beats per vector = popcount(data_i), or 1 if data_i == 0.
- Indices are strictly increasing within a vector. Every set bit, including bit WIDTH-1, is reported exactly once.
- data_i and data_val_i are ignored outside IDLE. data_i is captured at the accepting edge and may change afterwards.
- **Reset (arst_i high, at any time including mid-vector)**
  - Immediately: state = IDLE, pend = 0, data_ready_o = 0, index_val_o = 0.
  - Any partially sent vector is discarded.
  - After release, data_ready_o rises at the first clock edge.
- Output-side values are decoded from registered state/pend only. There is no combinational path from data_i or index_ready_i to any output.

## Timing
- Input accepted at edge k → first beat valid in the cycle after edge k (latency 1).
- With index_ready_i held high, beats issue at one per cycle.
- The last transfer at edge m returns the block to IDLE, so data_ready_o = 1 in the cycle after edge m. The next vector can be accepted at edge m+1.
- Sustained throughput: popcount + 1 cycles per vector (empty vector: 2 cycles).
- Reset values: data_ready_o 0, index_val_o 0, index_o 0, index_empty_o 0, index_last_o 0.

## Test plan
- **Basic enumeration.** WIDTH=16, data_i=16'h8421, index_ready_i=1.
  - Beats: 0, 5, 10, 15, with last only on 15.
  - data_ready_o low for exactly 4 cycles after acceptance.
- **Empty and full vectors.**
  - data_i=0 → one beat with index_empty_o=1, index_last_o=1, index_o=0.
  - data_i=16'hFFFF → 16 beats with indices 0..15, last on 15.
- **Backpressure.** data_i=16'h0030 with index_ready_i toggling 0,0,1,0,1.
  - Index 4 held stable through the stall; then index 5 with last.
  - No duplicates or drops.
- **Back-to-back vectors.** data_val_i held high with vectors 16'h0001 then 16'h0003.
  - Beats: 0(last), bubble cycle with data_ready_o=1, then 0, 1(last).
  - data_i changed mid-SEND is ignored.
- **Reset mid-vector.** Accept 16'h00FF, take 3 beats, then assert arst_i asynchronously between edges.
  - index_val_o drops immediately.
  - After release: data_ready_o=1 at the first edge, and no stale beats appear.
- **Non-power-of-two width.** WIDTH=10, data_i=10'b10_0000_0001.
  - Beats: 0, 9(last), with IW=4.
- **Randomized check.** Randomized vectors and backpressure checked against a reference model of set-bit positions.
